dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder: the memory end of the Zz data bus driven by the CPU's memory stage.
- Accepts word address, big-endian byte-lane write enables and replicated store data; returns read words on zZ_din one cycle after a read request.
- Internal single-port synchronous RAM sits behind a one-entry posted store buffer with read forwarding, so the bus never stalls.
- Region addr[31]=1 belongs to MMIO and is not served here.

Parameters:
ADDR_W, 10, word-address bits; RAM depth = 2**ADDR_W words of 32 bits (4 KB default)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- pause  in  1  pipeline hold; requests ignored while 1
- Zz_addr  in  32  byte address; word index = Zz_addr[ADDR_W+1:2], bits [30:ADDR_W+2] ignored (aliasing)
- Zz_dout  in  32  store data, already lane-replicated by the initiator
- Zz_wr_en  in  4  byte-lane write enables; [3]=bits 31:24 (byte addr 0) ... [0]=bits 7:0 (byte addr 3)
- Zz_rd_en  in  1  read request for the current Zz_addr
- zZ_din  out  32  registered read data
- buf_valid  out  1  store buffer holds an uncommitted write

Behaviour:
- Reset (rst=0 at a clock edge): buf_valid=0, zZ_din=0, forward registers cleared. RAM contents are not reset. A buffered write pending at reset is discarded, never committed.
- Accepted request: pause=0 and Zz_addr[31]=0. Write = accepted and Zz_wr_en!=0. Read = accepted, Zz_rd_en=1 and Zz_wr_en=0.
- Write priority: Zz_wr_en!=0 together with Zz_rd_en=1 is treated as a write only; zZ_din holds its previous value.
- Store buffer: one entry {word address, 32-bit data, 4-bit lane mask}.
  - Write with buffer empty: load the entry; buf_valid=1 next cycle.
  - Write with buffer valid, different word: commit the old entry to RAM (lane-masked) this cycle; load the new entry.
  - Write with buffer valid, same word: merge in place. New lanes overwrite, mask = old|new; no RAM access.
- RAM port use, one access per cycle, priority order:
  1. Read request.
  2. Commit forced by a new write.
  3. Drain: buffer valid and the cycle carries no accepted read or write, including pause=1 cycles. Commit lane-masked; buf_valid=0 next cycle.
- Read:
  - RAM read is issued and the buffer snapshot is captured in the request cycle.
  - Next cycle zZ_din = RAM word with lanes replaced by buffer data where buffer valid, address matches and mask bit is set.
  - Latency is exactly 1 cycle.
- Back-to-back reads each get one-cycle data. A read directly after a write to the same word returns the new bytes via forwarding.
- zZ_din updates only the cycle after an accepted read and holds otherwise, including throughout pause. This matches the initiator's paused capture.
- addr[31]=1: no RAM or buffer effect. A read there loads zZ_din=0 next cycle.
- Partial writes (SB/SH/SWL/SWR masks) alter only enabled lanes. Mask 0000 is not a write.
- RAM modelled as four byte-wide arrays.

Optional Feature:
- DMEM_BUS_ERR_EN defined: adds output bus_err (1 bit, reset 0). It is a registered one-cycle pulse the cycle after any request with pause=0 that either:
  - targets addr[31]=1 with Zz_wr_en!=0 or Zz_rd_en=1, or
  - asserts Zz_wr_en!=0 and Zz_rd_en=1 together.
- Undefined: port absent, no error logic; data behaviour identical.

Test Plan:
1. Reset, then SW addr 0x10 data 0x11223344 mask 1111, idle cycle, read 0x10 -> buf_valid 1 then 0 after drain; zZ_din=0x11223344 one cycle after read.
2. SW 0x20 = 0xAABBCCDD, immediately SB to 0x21 data 0x55555555 mask 0100, immediately read 0x20 -> no drain between; zZ_din=0xAA55CCDD via forwarding.
3. SW 0x30=0x01020304 then SW 0x34=0x05060708 back-to-back, reads 0x30 and 0x34 -> forced commit path; 0x01020304, 0x05060708.
4. Read 0x40 (RAM 0xDEADBEEF) with pause asserted next 3 cycles and an idle drain pending -> zZ_din stays 0xDEADBEEF throughout; buffer drains during pause.
5. SW 0x50 then rst=0 next cycle, release, read 0x50 -> write lost; zZ_din equals prior RAM contents; buf_valid=0 after reset.
6. Read 0x80000004 (with DMEM_BUS_ERR_EN) -> zZ_din=0, bus_err one-cycle pulse; simultaneous wr 1111 + rd to 0x60 -> write done, zZ_din unchanged, bus_err pulse.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane RAM behind a one-entry posted store buffer with read forwarding.
// Optional DMEM_BUS_ERR_EN adds a registered bus_err pulse for MMIO-region and write+read-collision requests.
module dmem_responder #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause,
  input  logic [31:0] Zz_addr,
  input  logic [31:0] Zz_dout,
  input  logic [3:0]  Zz_wr_en,
  input  logic        Zz_rd_en,
  output logic [31:0] zZ_din,
`ifdef DMEM_BUS_ERR_EN
  output logic        bus_err,
`endif
  output logic        buf_valid
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned LANES = 4;

  logic [7:0]        lane_mem [LANES][DEPTH];

  logic [ADDR_W-1:0] idx;
  logic              accepted, wr_acc, rd_acc, rd_mmio, hit, commit;

  logic [ADDR_W-1:0] buf_addr, buf_addr_d;
  logic [31:0]       buf_data, buf_data_d;
  logic [3:0]        buf_mask, buf_mask_d;
  logic              buf_valid_d;

  logic [31:0]       ram_q, fwd_data;
  logic [3:0]        fwd_mask;

  logic              unused_addr_bits;

  assign idx              = Zz_addr[ADDR_W+1:2];
  assign unused_addr_bits = ^{Zz_addr[30:ADDR_W+2], Zz_addr[1:0]};

  // Request decode, buffer next-state and RAM port arbitration
  always_comb begin
    accepted    = !pause && !Zz_addr[31];
    wr_acc      = accepted && (Zz_wr_en != 4'b0000);
    rd_acc      = accepted && Zz_rd_en && (Zz_wr_en == 4'b0000);
    rd_mmio     = !pause && Zz_addr[31] && Zz_rd_en && (Zz_wr_en == 4'b0000);
    hit         = buf_valid && (buf_addr == idx);
    // Reads own the port; otherwise commit on a displacing write or an idle cycle
    commit      = buf_valid && ((wr_acc && !hit) || (!wr_acc && !rd_acc));
    buf_valid_d = buf_valid;
    buf_addr_d  = buf_addr;
    buf_data_d  = buf_data;
    buf_mask_d  = buf_mask;
    if (wr_acc) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = idx;
      if (hit) begin
        for (int i = 0; i < LANES; i++) begin
          if (Zz_wr_en[i]) buf_data_d[8*i +: 8] = Zz_dout[8*i +: 8];
        end
        buf_mask_d = buf_mask | Zz_wr_en;
      end else begin
        buf_data_d = Zz_dout;
        buf_mask_d = Zz_wr_en;
      end
    end else if (commit) begin
      buf_valid_d = 1'b0;
    end
  end

  // RAM contents are never reset; a commit in a reset cycle is dropped
  always_ff @(posedge clk) begin
    if (rst && commit) begin
      for (int i = 0; i < LANES; i++) begin
        if (buf_mask[i]) lane_mem[i][buf_addr] <= buf_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
      buf_mask  <= '0;
      ram_q     <= '0;
      fwd_data  <= '0;
      fwd_mask  <= '0;
    end else begin
      buf_valid <= buf_valid_d;
      buf_addr  <= buf_addr_d;
      buf_data  <= buf_data_d;
      buf_mask  <= buf_mask_d;
      if (rd_acc) begin
        for (int i = 0; i < LANES; i++) begin
          ram_q[8*i +: 8] <= lane_mem[i][idx];
        end
        fwd_data <= buf_data;
        fwd_mask <= hit ? buf_mask : 4'b0000;
      end else if (rd_mmio) begin
        ram_q    <= '0;
        fwd_mask <= 4'b0000;
      end
    end
  end

  // Read word: RAM data with buffered lanes overlaid; only changes after a read
  always_comb begin
    zZ_din = ram_q;
    for (int i = 0; i < LANES; i++) begin
      if (fwd_mask[i]) zZ_din[8*i +: 8] = fwd_data[8*i +: 8];
    end
  end

`ifdef DMEM_BUS_ERR_EN
  logic bus_err_d;

  always_comb begin
    bus_err_d = !pause &&
                ((Zz_addr[31] && ((Zz_wr_en != 4'b0000) || Zz_rd_en)) ||
                 ((Zz_wr_en != 4'b0000) && Zz_rd_en));
  end

  always_ff @(posedge clk) begin
    if (!rst) bus_err <= 1'b0;
    else      bus_err <= bus_err_d;
  end
`endif

endmodule
